// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, instruction-field encodings,
// execution-unit FSM states and the base func3 decode.
package alu_pkg;

  typedef enum logic [3:0] {
    CTRL_AND  = 4'b0000,
    CTRL_OR   = 4'b0001,
    CTRL_ADD  = 4'b0010,
    CTRL_XOR  = 4'b0011,
    CTRL_SLL  = 4'b0100,
    CTRL_SRL  = 4'b0101,
    CTRL_SUB  = 4'b0110,
    CTRL_SLT  = 4'b0111,
    CTRL_SRA  = 4'b1000,
    CTRL_SLTU = 4'b1001,
    CTRL_MUL  = 4'b1010
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] ALU_OP_LS = 2'b00;
  localparam logic [1:0] ALU_OP_BR = 2'b01;
  localparam logic [1:0] ALU_OP_R  = 2'b10;
  localparam logic [1:0] ALU_OP_I  = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // func3 decode shared by R-type (func7 = base) and I-type
  function automatic ctrl_t base_op(input logic [2:0] func3);
    case (func3)
      3'b000:  base_op = CTRL_ADD;
      3'b001:  base_op = CTRL_SLL;
      3'b010:  base_op = CTRL_SLT;
      3'b011:  base_op = CTRL_SLTU;
      3'b100:  base_op = CTRL_XOR;
      3'b101:  base_op = CTRL_SRL;
      3'b110:  base_op = CTRL_OR;
      default: base_op = CTRL_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU control decode: alu_op/func3/func7 -> 4-bit control code.
module alu_decode
  import alu_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [3:0] ctrl
);

  ctrl_t dec;

  always_comb begin
    dec = CTRL_ADD;
    case (alu_op)
      ALU_OP_LS: dec = CTRL_ADD;
      ALU_OP_BR: dec = CTRL_SUB;
      ALU_OP_R: begin
        case (func7)
          F7_BASE: dec = base_op(func3);
          F7_ALT: begin
            if (func3 == 3'b000)      dec = CTRL_SUB;
            else if (func3 == 3'b101) dec = CTRL_SRA;
          end
          F7_MULDIV: begin
            if (MUL_EN && func3 == 3'b000) dec = CTRL_MUL;
          end
          default: dec = CTRL_ADD;
        endcase
      end
      default: begin
        // I-type: func7 only distinguishes SRA from SRL
        dec = base_op(func3);
        if (func3 == 3'b101 && func7 == F7_ALT) dec = CTRL_SRA;
      end
    endcase
  end

  assign ctrl = dec;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ops plus iterative shift-add multiply,
// with a valid/ready handshake on both sides and a held output register.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       ctrl
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  state_t           state, state_nxt;
  logic [3:0]       dec_ctrl;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CW-1:0]    cnt;
  logic [SHW-1:0]   shamt;
  logic             accept, is_mul, mul_done;

  alu_decode #(.MUL_EN(MUL_EN)) u_decode (
    .alu_op (alu_op),
    .func3  (func3),
    .func7  (func7),
    .ctrl   (dec_ctrl)
  );

  assign shamt    = op_b[SHW-1:0];
  assign is_mul   = (dec_ctrl == CTRL_MUL);
  assign in_ready = (state == ST_IDLE) || (state == ST_HOLD && out_ready);
  assign accept   = in_valid && in_ready;
  assign mul_done = (cnt == CW'(WIDTH));

  always_comb begin
    alu_res = '0;
    case (ctrl_t'(dec_ctrl))
      CTRL_AND:  alu_res = op_a & op_b;
      CTRL_OR:   alu_res = op_a | op_b;
      CTRL_XOR:  alu_res = op_a ^ op_b;
      CTRL_SLL:  alu_res = op_a << shamt;
      CTRL_SRL:  alu_res = op_a >> shamt;
      CTRL_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      CTRL_SUB:  alu_res = op_a - op_b;
      CTRL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      CTRL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      default:   alu_res = op_a + op_b;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = is_mul ? ST_MUL : ST_HOLD;
      ST_MUL:  if (mul_done) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (accept)         state_nxt = is_mul ? ST_MUL : ST_HOLD;
        else if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // One multiplier bit per cycle for WIDTH cycles, then one more cycle to
  // move the accumulator into the result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      ctrl_q   <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
    end else if (accept) begin
      ctrl_q <= dec_ctrl;
      if (is_mul) begin
        acc    <= '0;
        mcand  <= op_a;
        mplier <= op_b;
        cnt    <= '0;
      end else begin
        result_q <= alu_res;
      end
    end else if (state == ST_MUL) begin
      if (mul_done) begin
        result_q <= acc;
      end else begin
        acc    <= acc + (mplier[0] ? mcand : '0);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end

  assign out_valid = (state == ST_HOLD);
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign ctrl      = ctrl_q;

endmodule
